// File: rtl/kws_wb_sample_bridge.sv
// Wishbone slave that buffers CPU-written audio samples for the keyword-spotting core
// and latches its classification results behind a maskable level interrupt.
module kws_wb_sample_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLASS_W    = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                smp_valid_o,
    output logic [SAMPLE_W-1:0] smp_data_o,
    input  logic                smp_ready_i,
    input  logic                res_valid_i,
    input  logic [CLASS_W-1:0]  res_class_i,
    input  logic [15:0]         res_score_i,
    output logic                irq_o
);
    localparam int unsigned      LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned      PTR_W    = LVL_W - 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_STATUS = 8'h04;
    localparam logic [7:0] OFS_SAMPLE = 8'h08;
    localparam logic [7:0] OFS_RESULT = 8'h0C;
    localparam logic [7:0] OFS_IRQ    = 8'h10;

    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_enable;
    logic                r_irq_res_en;
    logic                r_irq_ovf_en;
    logic                r_flush;
    logic                r_overflow;
    logic                r_result_valid;
    logic                r_res_pend;
    logic                r_ovf_pend;
    logic                r_irq;
    logic [CLASS_W-1:0]  r_class;
    logic [15:0]         r_score;
    logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;

    logic        w_sel_hit;
    logic        w_wr;
    logic        w_rd;
    logic [7:0]  w_ofs;
    logic        w_empty;
    logic        w_full;
    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_push_ok;
    logic        w_ovf_set;
    logic        w_irq_wr;
    logic        w_res_clr;
    logic        w_ovf_clr;
    logic        w_res_rd;
    logic [31:0] w_rdata;
    logic        w_unused;

    // The registered ack masks the second cycle of a held strobe, so each access takes two cycles.
    assign w_ofs     = wbs_adr_i[7:0];
    assign w_sel_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
    assign w_wr      = w_sel_hit & wbs_we_i & (|wbs_sel_i);
    assign w_rd      = w_sel_hit & ~wbs_we_i;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LVL_FULL);
    assign w_valid   = r_enable & ~w_empty;
    assign w_pop     = w_valid & smp_ready_i;
    assign w_push    = w_wr & (w_ofs == OFS_SAMPLE);
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    assign w_irq_wr  = w_wr & (w_ofs == OFS_IRQ);
    assign w_res_clr = w_irq_wr & wbs_dat_i[0];
    assign w_ovf_clr = w_irq_wr & wbs_dat_i[1];
    assign w_res_rd  = w_rd & (w_ofs == OFS_RESULT);
    assign w_unused  = ^wbs_dat_i;

    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            OFS_CTRL: w_rdata[2:0] = {r_irq_ovf_en, r_irq_res_en, r_enable};
            OFS_STATUS: begin
                w_rdata[0]         = w_empty;
                w_rdata[1]         = w_full;
                w_rdata[2]         = r_overflow;
                w_rdata[3]         = r_result_valid;
                w_rdata[LVL_W+7:8] = r_level;
            end
            OFS_RESULT: begin
                w_rdata[CLASS_W-1:0] = r_class;
                w_rdata[31:16]       = r_score;
            end
            OFS_IRQ: w_rdata[1:0] = {r_ovf_pend, r_res_pend};
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wbs_dat_i[SAMPLE_W-1:0];
        end
    end

    // When full with a same-cycle pop, wr_ptr equals rd_ptr and the head slot is reused.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || r_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack          <= 1'b0;
            r_dat          <= '0;
            r_enable       <= 1'b0;
            r_irq_res_en   <= 1'b0;
            r_irq_ovf_en   <= 1'b0;
            r_flush        <= 1'b0;
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b0;
            r_res_pend     <= 1'b0;
            r_ovf_pend     <= 1'b0;
            r_irq          <= 1'b0;
            r_class        <= '0;
            r_score        <= '0;
        end else begin
            r_ack   <= w_sel_hit;
            r_dat   <= w_rd ? w_rdata : '0;
            r_flush <= 1'b0;
            if (w_wr && (w_ofs == OFS_CTRL)) begin
                r_enable     <= wbs_dat_i[0];
                r_irq_res_en <= wbs_dat_i[1];
                r_irq_ovf_en <= wbs_dat_i[2];
                r_flush      <= wbs_dat_i[3];
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
                r_ovf_pend <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
                r_ovf_pend <= 1'b0;
            end
            // A hardware result beats a same-cycle RESULT read or W1C clear.
            if (res_valid_i) begin
                r_class        <= res_class_i;
                r_score        <= res_score_i;
                r_result_valid <= 1'b1;
                r_res_pend     <= 1'b1;
            end else begin
                if (w_res_rd) begin
                    r_result_valid <= 1'b0;
                end
                if (w_res_clr) begin
                    r_res_pend <= 1'b0;
                end
            end
            r_irq <= (r_res_pend & r_irq_res_en) | (r_ovf_pend & r_irq_ovf_en);
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign smp_valid_o = w_valid;
    assign smp_data_o  = r_mem[r_rd_ptr];
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_kws_wb_sample_bridge.sv
// Scoreboard bench for kws_wb_sample_bridge: a queue-based reference model predicts
// register reads, the sample stream and the interrupt line under directed and random traffic.
module tb_kws_wb_sample_bridge;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        smp_valid_o;
    logic [15:0] smp_data_o;
    logic        smp_ready_i;
    logic        res_valid_i;
    logic [3:0]  res_class_i;
    logic [15:0] res_score_i;
    logic        irq_o;

    always #5 clk = ~clk;

    kws_wb_sample_bridge dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .smp_valid_o (smp_valid_o),
        .smp_data_o  (smp_data_o),
        .smp_ready_i (smp_ready_i),
        .res_valid_i (res_valid_i),
        .res_class_i (res_class_i),
        .res_score_i (res_score_i),
        .irq_o       (irq_o)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on    = 1'b0;
    bit rand_done = 1'b0;
    bit prev_ack  = 1'b0;

    // Reference model state
    bit          m_en, m_res_en, m_ovf_en, m_flush;
    bit          m_ovf, m_rv, m_res_pend, m_ovf_pend, m_irq;
    logic [3:0]  m_class;
    logic [15:0] m_score;
    logic [15:0] m_q[$];

    // Access announced by the bus task, consumed by the model on the selecting edge
    bit          ev_valid = 1'b0;
    bit          ev_we;
    logic [7:0]  ev_ofs;
    logic [31:0] ev_dat;
    logic [3:0]  ev_sel;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        logic [7:0]  ofs;
    } sb_t;
    sb_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [7:0] ofs);
        logic [31:0] v;
        int          lvl;
        v   = '0;
        lvl = m_q.size();
        case (ofs)
            8'h00: v = {29'd0, m_ovf_en, m_res_en, m_en};
            8'h04: begin
                v    = 32'(lvl) << 8;
                v[0] = (lvl == 0);
                v[1] = (lvl == DEPTH);
                v[2] = m_ovf;
                v[3] = m_rv;
            end
            8'h0C: v = {m_score, 12'd0, m_class};
            8'h10: v = {30'd0, m_ovf_pend, m_res_pend};
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit          nirq, pop, hit, wr;
        logic [7:0]  ofs;
        logic [31:0] d;
        sb_t         e;
        if (!rst_n) begin
            m_en = 0; m_res_en = 0; m_ovf_en = 0; m_flush = 0;
            m_ovf = 0; m_rv = 0; m_res_pend = 0; m_ovf_pend = 0; m_irq = 0;
            m_class = '0; m_score = '0;
            m_q.delete();
            ev_valid = 0;
        end else begin
            nirq = (m_res_pend && m_res_en) || (m_ovf_pend && m_ovf_en);
            pop  = m_en && (m_q.size() > 0) && smp_ready_i;
            hit  = ev_valid;
            ev_valid = 0;
            ofs  = ev_ofs;
            d    = ev_dat;
            wr   = hit && ev_we && (ev_sel != 4'd0);
            if (hit) begin
                e.rd   = !ev_we;
                e.data = ev_we ? 32'd0 : mdl_read(ofs);
                e.ofs  = ofs;
                sb_q.push_back(e);
            end
            if (m_flush) begin
                m_q.delete();
                m_flush = 0;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (wr && ofs == 8'h08) begin
                    if (m_q.size() < DEPTH) m_q.push_back(d[15:0]);
                    else begin
                        m_ovf      = 1;
                        m_ovf_pend = 1;
                    end
                end
            end
            if (wr && ofs == 8'h00) begin
                m_en = d[0]; m_res_en = d[1]; m_ovf_en = d[2]; m_flush = d[3];
            end
            if (wr && ofs == 8'h10) begin
                if (d[0]) m_res_pend = 0;
                if (d[1]) begin
                    m_ovf      = 0;
                    m_ovf_pend = 0;
                end
            end
            if (hit && !ev_we && ofs == 8'h0C) m_rv = 0;
            if (res_valid_i) begin
                m_class = res_class_i; m_score = res_score_i; m_rv = 1; m_res_pend = 1;
            end
            m_irq = nirq;
        end
    end

    always @(posedge clk) begin : monitor
        sb_t e;
        #1;
        if (chk_on) begin
            if (wbs_ack_o) begin
                check("ack_not_back_to_back", 32'(prev_ack), 32'd0);
                if (sb_q.size() == 0) check("unexpected_ack", 32'(wbs_ack_o), 32'd0);
                else begin
                    e = sb_q.pop_front();
                    if (e.rd) check($sformatf("rdata_ofs%02h", e.ofs), wbs_dat_o, e.data);
                end
            end else begin
                check("dat_idle_zero", wbs_dat_o, 32'd0);
            end
            check("smp_valid", 32'(smp_valid_o), 32'(m_en && (m_q.size() > 0)));
            if (m_en && (m_q.size() > 0)) check("smp_data", 32'(smp_data_o), 32'(m_q[0]));
            check("irq", 32'(irq_o), 32'(m_irq));
        end
        prev_ack = wbs_ack_o;
    end

    task automatic wb_acc(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel = 4'hF, input bit pulse_ready = 1'b0,
                          input bit pulse_res = 1'b0);
        bit selected;
        bit seen;
        int n;
        selected = (adr[31:8] == BASE[31:8]);
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        if (pulse_ready) smp_ready_i = 1;
        if (pulse_res) res_valid_i = 1;
        ev_we = we; ev_ofs = adr[7:0]; ev_dat = dat; ev_sel = sel;
        ev_valid = selected;
        @(posedge clk);
        #1;
        if (pulse_ready) smp_ready_i = 0;
        if (pulse_res) res_valid_i = 0;
        if (selected) begin
            check("ack_one_cycle_after_stb", 32'(wbs_ack_o), 32'd1);
            n = 0;
            while (!wbs_ack_o && n < 4) begin
                @(posedge clk);
                #1;
                n++;
            end
        end else begin
            seen = wbs_ack_o;
            repeat (3) begin
                @(posedge clk);
                #1;
                seen |= wbs_ack_o;
            end
            check("no_ack_unselected", 32'(seen), 32'd0);
        end
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          op;
        rst_n = 0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
        wbs_adr_i = '0; wbs_dat_i = '0;
        smp_ready_i = 0; res_valid_i = 0; res_class_i = '0; res_score_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(wbs_ack_o), 32'd0);
        check("reset_dat", wbs_dat_o, 32'd0);
        check("reset_valid", 32'(smp_valid_o), 32'd0);
        check("reset_data", 32'(smp_data_o), 32'd0);
        check("reset_irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        rst_n  = 1;
        chk_on = 1;

        // Reset status, then a three-sample stream
        wb_acc(0, BASE + 32'h04, 0);
        wb_acc(1, BASE + 32'h00, 32'h1);
        wb_acc(1, BASE + 32'h08, 32'h1111);
        wb_acc(1, BASE + 32'h08, 32'h2222);
        wb_acc(1, BASE + 32'h08, 32'h3333);
        wb_acc(0, BASE + 32'h04, 0);
        @(negedge clk); smp_ready_i = 1;
        repeat (5) @(negedge clk);
        smp_ready_i = 0;

        // Overflow with the FIFO disabled, then W1C of ovf_pend
        wb_acc(1, BASE + 32'h00, 32'h4);
        for (int i = 0; i < 17; i++) wb_acc(1, BASE + 32'h08, $urandom);
        wb_acc(0, BASE + 32'h04, 0);
        repeat (2) @(negedge clk);
        wb_acc(1, BASE + 32'h10, 32'h2);
        wb_acc(0, BASE + 32'h04, 0);

        // Push into a full FIFO on the same cycle as a pop
        wb_acc(1, BASE + 32'h00, 32'h1);
        wb_acc(1, BASE + 32'h08, 32'hBEEF, 4'hF, 1'b1);
        wb_acc(0, BASE + 32'h04, 0);
        @(negedge clk); smp_ready_i = 1;
        repeat (20) @(negedge clk);
        smp_ready_i = 0;

        // Result latch, RESULT read, interrupt
        wb_acc(1, BASE + 32'h00, 32'h3);
        @(negedge clk);
        res_valid_i = 1; res_class_i = 4'd5; res_score_i = 16'h00A0;
        @(negedge clk);
        res_valid_i = 0;
        repeat (2) @(negedge clk);
        wb_acc(0, BASE + 32'h0C, 0);
        wb_acc(0, BASE + 32'h04, 0);
        wb_acc(0, BASE + 32'h10, 0);

        // W1C racing a new result, then a clean clear
        res_class_i = 4'd9; res_score_i = 16'h1234;
        wb_acc(1, BASE + 32'h10, 32'h1, 4'hF, 1'b0, 1'b1);
        wb_acc(0, BASE + 32'h10, 0);
        wb_acc(0, BASE + 32'h0C, 0);
        wb_acc(1, BASE + 32'h10, 32'h1);
        wb_acc(0, BASE + 32'h10, 0);

        // Zero byte-select write is ignored
        wb_acc(1, BASE + 32'h00, 32'h0, 4'h0);
        wb_acc(0, BASE + 32'h00, 0);

        // Flush keeps the sticky overflow
        wb_acc(1, BASE + 32'h00, 32'h0);
        for (int i = 0; i < 17; i++) wb_acc(1, BASE + 32'h08, $urandom);
        wb_acc(1, BASE + 32'h00, 32'h8);
        wb_acc(0, BASE + 32'h04, 0);
        wb_acc(0, BASE + 32'h00, 0);
        wb_acc(1, BASE + 32'h10, 32'h2);

        // Unselected page and unmapped offsets
        wb_acc(0, BASE + 32'h100, 0);
        wb_acc(1, BASE + 32'h100, 32'h1);
        wb_acc(0, BASE + 32'h14, 0);
        wb_acc(1, BASE + 32'h18, 32'hFFFF_FFFF);
        wb_acc(0, BASE + 32'h08, 0);

        // Random traffic with random core-side handshakes
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    op = $urandom_range(0, 9);
                    d  = $urandom;
                    case (op)
                        0, 1, 2, 3: wb_acc(1, BASE + 32'h08, d);
                        4: wb_acc(0, BASE + 32'h04, 0);
                        5: wb_acc(0, BASE + 32'h0C, 0);
                        6: wb_acc(0, BASE + 32'h10, 0);
                        7: wb_acc(1, BASE + 32'h10, {30'd0, d[1:0]});
                        8: wb_acc(1, BASE + 32'h00, {28'd0, (d[7:5] == 3'd0), d[2:0]});
                        default: wb_acc(d[31], BASE + {24'd0, 3'(d[10:8] % 6), 2'b00},
                                        {28'd0, (d[7:4] == 4'd0), d[2:0]}, d[15:12]);
                    endcase
                    if (d[20]) @(negedge clk);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    smp_ready_i = ($urandom_range(0, 1) == 1);
                    res_valid_i = ($urandom_range(0, 7) == 0);
                    res_class_i = 4'($urandom);
                    res_score_i = 16'($urandom);
                end
                smp_ready_i = 0;
                res_valid_i = 0;
            end
        join

        wb_acc(0, BASE + 32'h04, 0);
        wb_acc(0, BASE + 32'h10, 0);
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kws_wb_sample_bridge.md
Name: kws_wb_sample_bridge

Overview:
- Parametrised Wishbone slave between the management SoC and the keyword-spotting core.
- Buffers CPU-written audio samples in a FIFO and streams them to the KWS core over a valid/ready interface.
- Latches classification results from the core and raises a maskable interrupt on result or FIFO overflow.
- Instantiated inside the user project wrapper; drives one user_irq line.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode compares wbs_adr_i[31:8].
- SAMPLE_W, 16, sample width in bits (1..32).
- FIFO_DEPTH, 16, sample FIFO depth; power of two, >= 2.
- CLASS_W, 4, width of the result class index (1..8).
- LVL_W, $clog2(FIFO_DEPTH)+1, FIFO level width (derived, not overridden).

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- smp_valid_o  out  1  sample available to the core.
- smp_data_o  out  SAMPLE_W  FIFO head sample.
- smp_ready_i  in  1  core accepts the sample.
- res_valid_i  in  1  one-cycle result strobe from the core.
- res_class_i  in  CLASS_W  result class.
- res_score_i  in  16  result score.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (wb_rst_ni low at a clock edge) clears all state.
  - Outputs: wbs_ack_o=0, wbs_dat_o=0, smp_valid_o=0, smp_data_o=0, irq_o=0.
  - FIFO empty, all registers 0.
  - Reset asserted mid-transaction drops the transaction; no ack.
- Selection: sel_hit = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]) & ~wbs_ack_o.
- Ack timing:
  - wbs_ack_o is registered; it pulses for 1 cycle, the cycle after sel_hit.
  - Minimum 2 cycles per access.
  - Unselected addresses get no ack.
- Register effects and wbs_dat_o both occur on the ack cycle. wbs_dat_o=0 when not acking.
- Register map (offset adr[7:0]); unmapped offsets ack, read 0, ignore writes:
  - 0x00 CTRL RW: [0] enable; [1] irq_res_en; [2] irq_ovf_en; [3] flush.
    - flush is write-1, self-clearing; it empties the FIFO next cycle and reads as 0.
  - 0x04 STATUS RO: [0] empty; [1] full; [2] overflow (sticky); [3] result_valid; [LVL_W+7:8] level.
  - 0x08 SAMPLE WO: write pushes wbs_dat_i[SAMPLE_W-1:0]. Reads return 0.
  - 0x0C RESULT RO: [CLASS_W-1:0] class, [31:16] score. A read clears result_valid.
  - 0x10 IRQ_STAT W1C: [0] res_pend; [1] ovf_pend.
- Writes with wbs_sel_i==0 are acked and ignored. Any nonzero sel writes the full register.
- FIFO:
  - Show-ahead: smp_data_o = head entry.
  - smp_valid_o = enable & ~empty.
  - Pop when smp_valid_o & smp_ready_i.
- Push on a full FIFO:
  - With no pop in the same cycle: sample dropped; set overflow and ovf_pend.
  - With a same-cycle pop: push accepted; level unchanged.
- Pointers are LVL_W-1 bits and wrap modulo FIFO_DEPTH. level = push count - pop count (0..FIFO_DEPTH).
- enable=0: smp_valid_o=0; FIFO contents retained; pushes still accepted.
- Flush: level→0 and smp_valid_o→0 on the following cycle. overflow is not cleared.
  - A push on the ack cycle of the flush write is impossible (single outstanding access).
- overflow is cleared only by writing 1 to IRQ_STAT[1] or by reset.
- Results:
  - res_valid_i latches class and score; sets result_valid and res_pend.
  - A new result overwrites unread data.
- Simultaneous events: a hardware set in the same cycle as a W1C clear or RESULT read wins (bit stays 1).
- irq_o is registered: irq_o = (res_pend & irq_res_en) | (ovf_pend & irq_ovf_en), 1-cycle latency.

Test Plan:
- Reset, then read STATUS at 0x3000_0004 → 0x0000_0001 (empty, level 0). Ack exactly 1 cycle after stb; ack never on 2 consecutive cycles.
- CTRL=1; write samples 0x1111, 0x2222, 0x3333 with smp_ready_i=0 → level=3. Raise ready → smp_data_o streams 1111, 2222, 3333 on consecutive cycles, then smp_valid_o=0.
- enable=0, write 17 samples (depth 16) → STATUS = 0x0000_1006 (full, overflow, level 16, empty 0). With irq_ovf_en set, irq_o=1. W1C 0x2 → irq_o=0, overflow=0.
- FIFO full, enable=1, ready=1, push on a pop cycle → level stays 16; sample stored at the tail in order.
- res_valid_i with class=5, score=0x00A0, CTRL=0x3 → irq_o=1 next cycle. RESULT read = 0x00A0_0005; result_valid clears. res_pend stays set until W1C.
- W1C IRQ_STAT[0] in the same cycle as a new res_valid_i → res_pend remains 1. Flush write → level 0, overflow unchanged. Access at 0x3000_0100 → no ack.
